// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two prioritised
// write ports with same-cycle bypass, per-register busy scoreboard and post-reset clear engine.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_dout,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic                i_wr0_en,
  input  logic [AW-1:0]       i_wr0_addr,
  input  logic [XLEN-1:0]     i_wr0_data,
  input  logic                i_wr1_en,
  input  logic [AW-1:0]       i_wr1_addr,
  input  logic [XLEN-1:0]     i_wr1_data,
  input  logic                i_sb_set,
  input  logic [AW-1:0]       i_sb_addr,
  output logic                o_init_done,
  output logic                o_dbg_state
);

  // Handshake: none. Writes, scoreboard sets and reads are single-cycle and
  // unqualified; they take effect only while the FSM is in RUN.

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem [NREGS];

  logic              run;
  logic              wr0_ok, wr1_ok;
  logic [AW-1:0]     ra;
  logic              hit0, hit1;

  assign run         = (state_q == S_RUN);
  assign o_init_done = run;
  assign o_dbg_state = state_q;

  // Writes to the hard-wired zero register are dropped before reaching storage.
  assign wr0_ok = run && i_wr0_en && !((ZERO_REG != 0) && (i_wr0_addr == '0));
  assign wr1_ok = run && i_wr1_en && !((ZERO_REG != 0) && (i_wr1_addr == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == LAST) state_d = S_RUN;
        else               cnt_d   = cnt_q + 1'b1;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Storage has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_q == S_INIT) begin
        mem[cnt_q] <= '0;
      end else begin
        if (wr0_ok) mem[i_wr0_addr] <= i_wr0_data;
        if (wr1_ok) mem[i_wr1_addr] <= i_wr1_data;
      end
    end
  end

  // Clear on writeback first, then set on issue so a new producer wins the race.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (i_wr0_en) busy_d[i_wr0_addr] = 1'b0;
      if (i_wr1_en) busy_d[i_wr1_addr] = 1'b0;
      if (i_sb_set) busy_d[i_sb_addr]  = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_comb begin
    o_rs_dout = '0;
    o_rs_busy = '0;
    ra        = '0;
    hit0      = 1'b0;
    hit1      = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra   = i_rs_addr[k*AW +: AW];
      hit0 = i_wr0_en && (i_wr0_addr == ra);
      hit1 = i_wr1_en && (i_wr1_addr == ra);
      if (run) begin
        if ((ZERO_REG != 0) && (ra == '0)) o_rs_dout[k*XLEN +: XLEN] = '0;
        else if (hit1)                     o_rs_dout[k*XLEN +: XLEN] = i_wr1_data;
        else if (hit0)                     o_rs_dout[k*XLEN +: XLEN] = i_wr0_data;
        else                               o_rs_dout[k*XLEN +: XLEN] = mem[ra];
        o_rs_busy[k] = busy_q[ra] && !(hit0 || hit1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default parameters): INIT timing, reset restart,
// write collision, bypass, zero register and scoreboard races.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [NRD*AW-1:0]   i_rs_addr;
  logic [NRD*XLEN-1:0] o_rs_dout;
  logic [NRD-1:0]      o_rs_busy;
  logic                i_wr0_en, i_wr1_en, i_sb_set;
  logic [AW-1:0]       i_wr0_addr, i_wr1_addr, i_sb_addr;
  logic [XLEN-1:0]     i_wr0_data, i_wr1_data;
  logic                o_init_done;
  logic                o_dbg_state;

  int checks   = 0;
  int failures = 0;
  int cycles;

  regfile_mp dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rs_addr   (i_rs_addr),
    .o_rs_dout   (o_rs_dout),
    .o_rs_busy   (o_rs_busy),
    .i_wr0_en    (i_wr0_en),
    .i_wr0_addr  (i_wr0_addr),
    .i_wr0_data  (i_wr0_data),
    .i_wr1_en    (i_wr1_en),
    .i_wr1_addr  (i_wr1_addr),
    .i_wr1_data  (i_wr1_data),
    .i_sb_set    (i_sb_set),
    .i_sb_addr   (i_sb_addr),
    .o_init_done (o_init_done),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_wr0_en = 1'b0; i_wr0_addr = '0; i_wr0_data = '0;
    i_wr1_en = 1'b0; i_wr1_addr = '0; i_wr1_data = '0;
    i_sb_set = 1'b0; i_sb_addr  = '0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    i_wr0_en = 1'b1; i_wr0_addr = a; i_wr0_data = d;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    i_wr1_en = 1'b1; i_wr1_addr = a; i_wr1_data = d;
  endtask

  task automatic sb_set(input logic [AW-1:0] a);
    i_sb_set = 1'b1; i_sb_addr = a;
  endtask

  task automatic rd_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    i_rs_addr = {a1, a0};
  endtask

  function automatic logic [XLEN-1:0] dout(input int k);
    return o_rs_dout[k*XLEN +: XLEN];
  endfunction

  // Runs INIT to completion, checking it takes exactly 32 edges after the reset edge.
  task automatic wait_init(input string tag);
    cycles = 0;
    while (!o_init_done && cycles < 100) begin
      next_cycle();
      cycles++;
      if (cycles == 5) begin
        #1;
        check_eq({tag, "_init_dout0"}, dout(0), 32'h0);
        check_eq({tag, "_init_dout1"}, dout(1), 32'h0);
        check_eq({tag, "_init_busy"}, {30'h0, o_rs_busy}, 32'h0);
      end
    end
    check_eq({tag, "_init_cycles"}, cycles, 32'd32);
  endtask

  initial begin
    idle();
    rd_addr(5'd4, 5'd1);
    i_rst = 1'b1;
    next_cycle();
    i_rst = 1'b0;
    #1;
    check_eq("reset_done_low", {31'h0, o_init_done}, 32'h0);
    check_eq("reset_state", {31'h0, o_dbg_state}, 32'h0);

    // writes and sets during INIT must be ignored (bypass included)
    wr0(5'd4, 32'h0000ABCD);
    sb_set(5'd4);
    repeat (10) next_cycle();
    check_eq("mid_init_done_low", {31'h0, o_init_done}, 32'h0);
    check_eq("mid_init_dout", dout(0), 32'h0);
    i_rst = 1'b1;
    next_cycle();
    i_rst = 1'b0;
    wait_init("rst2");
    idle();
    #1;
    check_eq("run_done_high", {31'h0, o_init_done}, 32'h1);
    check_eq("x4_after_init", dout(0), 32'h0);
    check_eq("x1_after_init", dout(1), 32'h0);
    check_eq("x4_busy_after_init", {31'h0, o_rs_busy[0]}, 32'h0);

    // dual write collision: port 1 wins, in bypass and in storage
    wr0(5'd5, 32'h00001111);
    wr1(5'd5, 32'h00002222);
    rd_addr(5'd5, 5'd5);
    #1;
    check_eq("coll_bypass0", dout(0), 32'h00002222);
    check_eq("coll_bypass1", dout(1), 32'h00002222);
    next_cycle();
    idle();
    #1;
    check_eq("coll_stored", dout(0), 32'h00002222);

    // independent writes on both ports
    wr0(5'd6, 32'h00000066);
    wr1(5'd8, 32'h00000088);
    rd_addr(5'd6, 5'd8);
    #1;
    check_eq("split_bypass0", dout(0), 32'h00000066);
    check_eq("split_bypass1", dout(1), 32'h00000088);
    next_cycle();
    idle();
    #1;
    check_eq("split_stored0", dout(0), 32'h00000066);
    check_eq("split_stored1", dout(1), 32'h00000088);

    // port 0 bypass
    wr0(5'd7, 32'hDEADBEEF);
    rd_addr(5'd7, 5'd5);
    #1;
    check_eq("byp_x7", dout(0), 32'hDEADBEEF);
    check_eq("byp_x5_kept", dout(1), 32'h00002222);
    next_cycle();
    idle();
    #1;
    check_eq("x7_stored", dout(0), 32'hDEADBEEF);

    // zero register: writes and busy set are dropped
    wr0(5'd0, 32'hFFFFFFFF);
    wr1(5'd0, 32'hFFFFFFFF);
    sb_set(5'd0);
    rd_addr(5'd0, 5'd0);
    #1;
    check_eq("x0_same_cycle", dout(0), 32'h0);
    next_cycle();
    idle();
    #1;
    check_eq("x0_after", dout(1), 32'h0);
    check_eq("x0_busy", {30'h0, o_rs_busy}, 32'h0);

    // scoreboard set, then cleared by a port 0 write
    sb_set(5'd9);
    rd_addr(5'd9, 5'd9);
    #1;
    check_eq("x9_busy_set_cycle", {31'h0, o_rs_busy[0]}, 32'h0);
    next_cycle();
    idle();
    #1;
    check_eq("x9_busy_next", {31'h0, o_rs_busy[1]}, 32'h1);
    wr0(5'd9, 32'h00000099);
    #1;
    check_eq("x9_busy_wr_cycle", {31'h0, o_rs_busy[0]}, 32'h0);
    check_eq("x9_wr_bypass", dout(0), 32'h00000099);
    next_cycle();
    idle();
    #1;
    check_eq("x9_busy_after_wr", {31'h0, o_rs_busy[0]}, 32'h0);

    // race: write and set x3 together, set wins
    sb_set(5'd3);
    rd_addr(5'd3, 5'd9);
    next_cycle();
    idle();
    #1;
    check_eq("x3_busy", {31'h0, o_rs_busy[0]}, 32'h1);
    wr1(5'd3, 32'h00000033);
    sb_set(5'd3);
    #1;
    check_eq("x3_race_masked", {31'h0, o_rs_busy[0]}, 32'h0);
    next_cycle();
    idle();
    #1;
    check_eq("x3_race_still_busy", {31'h0, o_rs_busy[0]}, 32'h1);
    check_eq("x3_race_data", dout(0), 32'h00000033);

    // reset from RUN clears busy bits and contents
    i_rst = 1'b1;
    next_cycle();
    i_rst = 1'b0;
    wait_init("rst3");
    #1;
    check_eq("x3_busy_after_rst", {31'h0, o_rs_busy[0]}, 32'h0);
    check_eq("x3_data_after_rst", dout(0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next core generation. It has configurable width, depth and read-port count, and two prioritised write ports with same-cycle write-to-read bypass. It also provides a per-register busy scoreboard for hazard detection and a sequential post-reset clear engine, so it can map onto non-resettable storage. It sits in decode, replacing the single-write-port file, and feeds operands and busy flags to the hazard unit.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers; power of two, >= 2; AW = $clog2(NREGS) is derived
NRD, 2, number of read ports (>= 1)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_rs_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
o_rs_dout  out  NRD*XLEN  read data, combinational; port k occupies bits [k*XLEN +: XLEN]
o_rs_busy  out  NRD  scoreboard busy flag per read port, combinational
i_wr0_en  in  1  write port 0 enable (writeback of the older instruction)
i_wr0_addr  in  AW  write port 0 address
i_wr0_data  in  XLEN  write port 0 data
i_wr1_en  in  1  write port 1 enable (younger instruction; has priority)
i_wr1_addr  in  AW  write port 1 address
i_wr1_data  in  XLEN  write port 1 data
i_sb_set  in  1  mark a register busy (instruction issued with a destination)
i_sb_addr  in  AW  register to mark busy
o_init_done  out  1  high once the clear sequence has finished

Behaviour:
- The only clock is i_clk. Reset is synchronous and active-high on i_rst.
- Reset: FSM enters INIT; clear counter = 0; all busy bits = 0; o_init_done = 0.
- INIT state:
  - Writes 0 to entry[counter] each cycle, then increments the counter.
  - When counter == NREGS-1 and that entry is written, moves to RUN. INIT lasts exactly NREGS cycles.
  - o_rs_dout = 0 and o_rs_busy = 0 on all ports.
  - i_wr*_en and i_sb_set are ignored.
- RUN state: o_init_done = 1. The FSM remains in RUN until i_rst.
- i_rst asserted in any state, including mid-INIT: restarts INIT at counter 0 on the next edge.
- Writes (RUN): entry[addr] <= data at the clock edge.
  - Both ports enabled with the same address: port 1 data is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads (RUN), per port, priority order:
  1. address 0 with ZERO_REG=1 -> 0
  2. i_wr1_en and address match -> i_wr1_data
  3. i_wr0_en and address match -> i_wr0_data
  4. otherwise -> entry[addr]
  There is zero-cycle write-to-read bypass on both write ports.
- Scoreboard (RUN):
  - At the edge, busy[addr] is cleared by any enabled write to addr, then set by i_sb_set.
  - Same-cycle set and clear of the same register: set wins, because a new producer has issued.
  - busy[0] is held at 0 when ZERO_REG=1.
  - o_rs_busy[k] = busy[rs_addr_k] AND NOT (any write enabled to rs_addr_k this cycle). Data being written this cycle is available via bypass.
- Arithmetic: the counter is AW+1 bits or uses a terminal compare; no wrap past NREGS-1. No sign or width conversion is applied to data.

Test Plan:
- Reset, NREGS=32: assert i_rst for 1 cycle -> o_init_done low for exactly 32 cycles, then high; all reads return 0.
- Reset at INIT counter 10: assert i_rst again -> INIT restarts; o_init_done rises 32 cycles after the second reset.
- Dual write collision: write x5 with 0x1111 on port 0 and 0x2222 on port 1 in the same cycle -> same-cycle read of x5 gives 0x2222; next cycle x5 reads 0x2222.
- Bypass and zero register: write x7 = 0xDEADBEEF on port 0 while reading x7 -> 0xDEADBEEF in the same cycle; write x0 = 0xFFFFFFFF -> x0 reads 0 and busy[0] stays 0.
- Scoreboard: set x9 -> o_rs_busy = 1 on the following cycle; port 0 writes x9 -> o_rs_busy = 0 in the write cycle and afterwards.
- Scoreboard race: with x3 busy, write x3 and set x3 in the same cycle -> x3 remains busy.
- Writes during INIT: write x4 = 0xABCD while o_init_done = 0 -> after INIT completes, x4 reads 0.
